// File: rtl/vip_pkg.sv
// Shared constants and helpers for the binary 3x3 morphology blocks.
//   MODE_ERODE  : AND of the 9 window taps
//   MODE_DILATE : OR of the 9 window taps
//   clog2       : counter width helper, never returns less than 1 bit
package vip_pkg;

    localparam int unsigned MODE_ERODE  = 0;
    localparam int unsigned MODE_DILATE = 1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/vip_bit_matrix_3x3.sv
// 3x3 tap generator for a 1-bit pixel stream.
// Holds the column/row counters, the two line buffers (rows y-1 and y-2) and
// the column shift registers. Everything is registered on the clock that
// accepts a pixel, so taps appear one clock after the pixel.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   per_frame_vsync/href/clken    input sync; a pixel is accepted on href & clken
//   per_img_Bit                   input pixel
//   frame_start                   combinational: vsync rise seen this clock
//   tap_valid                     taps below belong to a freshly accepted pixel
//   taps[r][c]                    r: 0 = row y, 1 = y-1, 2 = y-2;
//                                 c: 0 = col x, 1 = x-1, 2 = x-2
//   col_ok1/col_ok2               columns x-1 / x-2 lie inside the image
//   row_ok1/row_ok2               rows y-1 / y-2 lie inside the image
module vip_bit_matrix_3x3
    import vip_pkg::*;
#(
    parameter int unsigned IMG_HDISP = 320,
    parameter int unsigned IMG_VDISP = 240
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            per_frame_vsync,
    input  logic            per_frame_href,
    input  logic            per_frame_clken,
    input  logic            per_img_Bit,
    output logic            frame_start,
    output logic            tap_valid,
    output logic [2:0][2:0] taps,
    output logic            col_ok1,
    output logic            col_ok2,
    output logic            row_ok1,
    output logic            row_ok2
);

    localparam int unsigned CW = clog2(IMG_HDISP);
    localparam int unsigned RW = clog2(IMG_VDISP);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_HDISP - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_VDISP - 1);

    logic [CW-1:0] col_q, col_d, cur_x;
    logic [RW-1:0] row_q, row_d, cur_y;
    logic          line_pix_q, line_pix_d;
    logic          vs_low_q;
    logic          href_q;
    logic          accept;
    logic          href_fall;
    logic          rd1, rd2;

    logic [IMG_HDISP-1:0] buf1_q;  // row y-1
    logic [IMG_HDISP-1:0] buf2_q;  // row y-2

    // A rise only counts once vsync has actually been seen low since reset, so a
    // reset released mid-frame does not fake a frame start.
    assign frame_start = per_frame_vsync & vs_low_q;
    assign accept      = per_frame_href & per_frame_clken;
    assign href_fall   = href_q & ~per_frame_href;

    // A pixel arriving together with the frame start is pixel (0,0).
    assign cur_x = frame_start ? '0 : col_q;
    assign cur_y = frame_start ? '0 : row_q;

    // Read-before-write: these see the contents from the previous rows.
    assign rd1 = buf1_q[cur_x];
    assign rd2 = buf2_q[cur_x];

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        line_pix_d = line_pix_q;
        if (frame_start) begin
            col_d      = '0;
            row_d      = '0;
            line_pix_d = 1'b0;
        end else if (href_fall) begin
            col_d      = '0;
            line_pix_d = 1'b0;
            if (line_pix_q && (row_q != ROW_MAX)) begin
                row_d = row_q + 1'b1;
            end
        end
        if (accept) begin
            col_d      = (cur_x == COL_MAX) ? COL_MAX : cur_x + 1'b1;
            line_pix_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            line_pix_q <= 1'b0;
            vs_low_q   <= 1'b0;
            href_q     <= 1'b0;
            buf1_q     <= '0;
            buf2_q     <= '0;
            tap_valid  <= 1'b0;
            taps       <= '0;
            col_ok1    <= 1'b0;
            col_ok2    <= 1'b0;
            row_ok1    <= 1'b0;
            row_ok2    <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            line_pix_q <= line_pix_d;
            vs_low_q   <= ~per_frame_vsync;
            href_q     <= per_frame_href;
            tap_valid  <= accept;
            if (accept) begin
                buf1_q[cur_x] <= per_img_Bit;
                buf2_q[cur_x] <= rd1;
                taps[0]       <= {taps[0][1:0], per_img_Bit};
                taps[1]       <= {taps[1][1:0], rd1};
                taps[2]       <= {taps[2][1:0], rd2};
                col_ok1       <= (cur_x != '0);
                col_ok2       <= (cur_x > CW'(1));
                row_ok1       <= (cur_y != '0);
                row_ok2       <= (cur_y > RW'(1));
            end
        end
    end

endmodule

// File: rtl/vip_bit_morph_3x3.sv
// Binary 3x3 erosion/dilation on a vsync/href/clken 1-bit stream.
// Sync and data leave exactly 3 clocks after they enter:
//   stage 1  line-buffer read and tap registration (vip_bit_matrix_3x3)
//   stage 2  window assembly, out-of-image taps replaced by the neutral value
//   stage 3  9-input AND/OR reduction, output forced 0 on the x==0 / y==0 border
// Output pixels and clken stay 0 until the first real vsync rise after reset.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   per_frame_vsync/href/clken       input sync
//   per_img_Bit                      input pixel
//   post_frame_vsync/href/clken      sync delayed 3 clocks (clken gated until armed)
//   post_img_Bit                     filtered pixel, aligned with post_frame_clken
module vip_bit_morph_3x3
    import vip_pkg::*;
#(
    parameter int unsigned IMG_HDISP = 320,
    parameter int unsigned IMG_VDISP = 240,
    parameter int unsigned MODE      = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic per_frame_vsync,
    input  logic per_frame_href,
    input  logic per_frame_clken,
    input  logic per_img_Bit,
    output logic post_frame_vsync,
    output logic post_frame_href,
    output logic post_frame_clken,
    output logic post_img_Bit
);

    // Value that leaves the reduction unchanged: 1 for AND, 0 for OR.
    localparam logic NEUTRAL = (MODE == MODE_ERODE);

    logic            frame_start;
    logic            tap_valid;
    logic [2:0][2:0] taps;
    logic            col_ok1, col_ok2, row_ok1, row_ok2;

    logic [2:0] vs_d, hr_d, ck_d;
    logic       armed_q;
    logic [8:0] win_d, win_q;
    logic       win_valid_q;
    logic       border_q;
    logic       reduced;
    logic       post_bit_q;
    logic [2:0] row_ok, col_ok;

    vip_bit_matrix_3x3 #(
        .IMG_HDISP(IMG_HDISP),
        .IMG_VDISP(IMG_VDISP)
    ) u_matrix (
        .clk            (clk),
        .rst_n          (rst_n),
        .per_frame_vsync(per_frame_vsync),
        .per_frame_href (per_frame_href),
        .per_frame_clken(per_frame_clken),
        .per_img_Bit    (per_img_Bit),
        .frame_start    (frame_start),
        .tap_valid      (tap_valid),
        .taps           (taps),
        .col_ok1        (col_ok1),
        .col_ok2        (col_ok2),
        .row_ok1        (row_ok1),
        .row_ok2        (row_ok2)
    );

    assign row_ok = {row_ok2, row_ok1, 1'b1};
    assign col_ok = {col_ok2, col_ok1, 1'b1};

    always_comb begin
        win_d = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_d[r*3+c] = (row_ok[r] & col_ok[c]) ? taps[r][c] : NEUTRAL;
            end
        end
    end

    always_comb begin
        reduced = (MODE == MODE_DILATE) ? (|win_q) : (&win_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d        <= '0;
            hr_d        <= '0;
            ck_d        <= '0;
            armed_q     <= 1'b0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            border_q    <= 1'b0;
            post_bit_q  <= 1'b0;
        end else begin
            vs_d        <= {vs_d[1:0], per_frame_vsync};
            hr_d        <= {hr_d[1:0], per_frame_href};
            ck_d        <= {ck_d[1:0], per_frame_clken & (armed_q | frame_start)};
            armed_q     <= armed_q | frame_start;
            win_q       <= win_d;
            // armed_q already includes a frame start that came with this pixel.
            win_valid_q <= tap_valid & armed_q;
            border_q    <= ~(col_ok1 & row_ok1);
            post_bit_q  <= win_valid_q & ~border_q & reduced;
        end
    end

    assign post_frame_vsync = vs_d[2];
    assign post_frame_href  = hr_d[2];
    assign post_frame_clken = ck_d[2];
    assign post_img_Bit     = post_bit_q;

endmodule

// File: tb/tb_vip_bit_morph_3x3.sv
module tb_vip_bit_morph_3x3;

    localparam int W = 20;
    localparam int H = 16;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic vs     = 1'b0;
    logic hr     = 1'b0;
    logic ck     = 1'b0;
    logic bit_in = 1'b0;

    logic e_vs, e_hr, e_ck, e_bit;
    logic d_vs, d_hr, d_ck, d_bit;

    int total = 0;
    int bad   = 0;

    bit img [H][W];
    bit q_e[$];
    bit q_d[$];
    bit collect_en = 1'b0;
    bit log_en     = 1'b0;
    bit watch_en   = 1'b0;
    int watch_hits = 0;
    bit lin_vs[$], lin_hr[$], lin_ck[$];
    bit lout_vs[$], lout_hr[$], lout_ck[$];

    always #5 clk = ~clk;

    vip_bit_morph_3x3 #(.IMG_HDISP(W), .IMG_VDISP(H), .MODE(0)) u_erode (
        .clk             (clk),
        .rst_n           (rst_n),
        .per_frame_vsync (vs),
        .per_frame_href  (hr),
        .per_frame_clken (ck),
        .per_img_Bit     (bit_in),
        .post_frame_vsync(e_vs),
        .post_frame_href (e_hr),
        .post_frame_clken(e_ck),
        .post_img_Bit    (e_bit)
    );

    vip_bit_morph_3x3 #(.IMG_HDISP(W), .IMG_VDISP(H), .MODE(1)) u_dilate (
        .clk             (clk),
        .rst_n           (rst_n),
        .per_frame_vsync (vs),
        .per_frame_href  (hr),
        .per_frame_clken (ck),
        .per_img_Bit     (bit_in),
        .post_frame_vsync(d_vs),
        .post_frame_href (d_hr),
        .post_frame_clken(d_ck),
        .post_img_Bit    (d_bit)
    );

    // Inputs change 1 time unit after a rising edge; everything is sampled here.
    always @(negedge clk) begin
        if (collect_en && e_hr && e_ck) q_e.push_back(e_bit);
        if (collect_en && d_hr && d_ck) q_d.push_back(d_bit);
        if (watch_en && (e_ck || d_ck || e_bit || d_bit)) watch_hits++;
        if (log_en) begin
            lin_vs.push_back(vs);
            lin_hr.push_back(hr);
            lin_ck.push_back(ck);
            lout_vs.push_back(e_vs);
            lout_hr.push_back(e_hr);
            lout_ck.push_back(e_ck);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Output for accepted pixel (x,y): 3x3 reduction over cols x-2..x, rows y-2..y,
    // off-image taps neutral, and 0 on the x==0 / y==0 border.
    function automatic bit golden(input int x, input int y, input bit dil);
        bit acc;
        bit v;
        if (x == 0 || y == 0) return 1'b0;
        acc = ~dil;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                if (y - dy < 0 || x - dx < 0) v = ~dil;
                else v = img[y-dy][x-dx];
                acc = dil ? (acc | v) : (acc & v);
            end
        end
        return acc;
    endfunction

    function automatic int ones(input bit q[$]);
        int n = 0;
        foreach (q[i]) n += int'(q[i]);
        return n;
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input int y, input bit gap);
        int x = 0;
        bit phase = 1'b1;
        hr = 1'b1;
        while (x < W) begin
            ck     = gap ? phase : 1'b1;
            bit_in = img[y][x];
            tick();
            if (ck) x++;
            phase = ~phase;
        end
        hr     = 1'b0;
        ck     = 1'b0;
        bit_in = 1'b0;
        repeat (6) tick();
    endtask

    task automatic frame_open;
        vs = 1'b0;
        hr = 1'b0;
        ck = 1'b0;
        repeat (4) tick();
        vs = 1'b1;
        repeat (3) tick();
    endtask

    task automatic frame_close;
        repeat (2) tick();
        vs = 1'b0;
        repeat (2) tick();
    endtask

    task automatic run_frame(input bit gap);
        q_e.delete();
        q_d.delete();
        collect_en = 1'b1;
        frame_open();
        for (int y = 0; y < H; y++) drive_line(y, gap);
        frame_close();
        collect_en = 1'b0;
    endtask

    task automatic random_image(input int density);
        foreach (img[y, x]) img[y][x] = ($urandom_range(0, 99) < density);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        total++;
        if ({e_vs, e_hr, e_ck, e_bit} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_erode got=%b exp=0000", {e_vs, e_hr, e_ck, e_bit});
        end
        total++;
        if ({d_vs, d_hr, d_ck, d_bit} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_dilate got=%b exp=0000", {d_vs, d_hr, d_ck, d_bit});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_all_ones;
        int n;
        foreach (img[y, x]) img[y][x] = 1'b1;
        run_frame(1'b0);
        total++;
        if (q_e.size() != W * H) begin
            bad++;
            $display("FAIL all_ones_count got=%0d exp=%0d", q_e.size(), W * H);
        end
        total++;
        if (ones(q_e) != (W - 1) * (H - 1)) begin
            bad++;
            $display("FAIL all_ones_ones got=%0d exp=%0d", ones(q_e), (W - 1) * (H - 1));
        end
        n = min2(q_e.size(), W * H);
        for (int i = 0; i < n; i++) begin
            total++;
            if (q_e[i] !== golden(i % W, i / W, 1'b0)) begin
                bad++;
                $display("FAIL all_ones_pix x=%0d y=%0d got=%0b exp=%0b",
                         i % W, i / W, q_e[i], golden(i % W, i / W, 1'b0));
            end
        end
    endtask

    task automatic test_single_dot;
        int n;
        foreach (img[y, x]) img[y][x] = 1'b0;
        img[5][5] = 1'b1;
        run_frame(1'b0);
        total++;
        if (ones(q_d) != 9) begin
            bad++;
            $display("FAIL dot_dilate_ones got=%0d exp=9", ones(q_d));
        end
        total++;
        if (ones(q_e) != 0) begin
            bad++;
            $display("FAIL dot_erode_ones got=%0d exp=0", ones(q_e));
        end
        total++;
        if (q_d.size() != W * H) begin
            bad++;
            $display("FAIL dot_count got=%0d exp=%0d", q_d.size(), W * H);
        end
        n = min2(q_d.size(), W * H);
        for (int i = 0; i < n; i++) begin
            total++;
            if (q_d[i] !== ((i % W) >= 5 && (i % W) <= 7 && (i / W) >= 5 && (i / W) <= 7)) begin
                bad++;
                $display("FAIL dot_dilate_pix x=%0d y=%0d got=%0b", i % W, i / W, q_d[i]);
            end
        end
    endtask

    task automatic test_block;
        foreach (img[y, x]) img[y][x] = (x >= 10 && x <= 12 && y >= 10 && y <= 12);
        run_frame(1'b0);
        total++;
        if (ones(q_e) != 1) begin
            bad++;
            $display("FAIL block_erode_ones got=%0d exp=1", ones(q_e));
        end
        total++;
        if (q_e.size() != W * H || q_e[12*W+12] !== 1'b1) begin
            bad++;
            $display("FAIL block_erode_at_12_12 size=%0d exp_size=%0d", q_e.size(), W * H);
        end
        total++;
        if (ones(q_d) != 25) begin
            bad++;
            $display("FAIL block_dilate_ones got=%0d exp=25", ones(q_d));
        end
    endtask

    task automatic test_random;
        int n;
        for (int k = 0; k < 2; k++) begin
            random_image(k == 0 ? 80 : 15);
            run_frame(1'b0);
            total++;
            if (q_e.size() != W * H || q_d.size() != W * H) begin
                bad++;
                $display("FAIL random_count got=%0d/%0d exp=%0d", q_e.size(), q_d.size(), W * H);
            end
            n = min2(min2(q_e.size(), q_d.size()), W * H);
            for (int i = 0; i < n; i++) begin
                total++;
                if (q_e[i] !== golden(i % W, i / W, 1'b0) || q_d[i] !== golden(i % W, i / W, 1'b1)) begin
                    bad++;
                    $display("FAIL random_pix x=%0d y=%0d got=%0b%0b exp=%0b%0b", i % W, i / W,
                             q_e[i], q_d[i], golden(i % W, i / W, 1'b0), golden(i % W, i / W, 1'b1));
                end
            end
        end
    endtask

    task automatic test_latency_gapped;
        int n;
        random_image(50);
        lin_vs.delete(); lin_hr.delete(); lin_ck.delete();
        lout_vs.delete(); lout_hr.delete(); lout_ck.delete();
        log_en = 1'b1;
        run_frame(1'b1);
        repeat (4) tick();
        log_en = 1'b0;
        for (int c = 0; c + 3 < lin_vs.size(); c++) begin
            total++;
            if ({lout_vs[c+3], lout_hr[c+3], lout_ck[c+3]} !== {lin_vs[c], lin_hr[c], lin_ck[c]}) begin
                bad++;
                $display("FAIL latency_sync cycle=%0d got=%b exp=%b", c + 3,
                         {lout_vs[c+3], lout_hr[c+3], lout_ck[c+3]}, {lin_vs[c], lin_hr[c], lin_ck[c]});
            end
        end
        total++;
        if (q_e.size() != W * H || q_d.size() != W * H) begin
            bad++;
            $display("FAIL gapped_count got=%0d/%0d exp=%0d", q_e.size(), q_d.size(), W * H);
        end
        n = min2(min2(q_e.size(), q_d.size()), W * H);
        for (int i = 0; i < n; i++) begin
            total++;
            if (q_e[i] !== golden(i % W, i / W, 1'b0) || q_d[i] !== golden(i % W, i / W, 1'b1)) begin
                bad++;
                $display("FAIL gapped_pix x=%0d y=%0d got=%0b%0b exp=%0b%0b", i % W, i / W,
                         q_e[i], q_d[i], golden(i % W, i / W, 1'b0), golden(i % W, i / W, 1'b1));
            end
        end
    endtask

    task automatic test_reset_midframe;
        int n;
        int hits0;
        random_image(60);
        frame_open();
        for (int y = 0; y < 6; y++) drive_line(y, 1'b0);
        hr     = 1'b1;
        ck     = 1'b1;
        bit_in = img[6][0];
        tick();
        bit_in = img[6][1];
        tick();
        total++;
        if (e_vs !== 1'b1 || d_vs !== 1'b1) begin
            bad++;
            $display("FAIL midframe_vsync_before got=%0b%0b exp=11", e_vs, d_vs);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({e_vs, e_hr, e_ck, e_bit, d_vs, d_hr, d_ck, d_bit} !== 8'h00) begin
            bad++;
            $display("FAIL midframe_reset_outputs got=%b exp=00000000",
                     {e_vs, e_hr, e_ck, e_bit, d_vs, d_hr, d_ck, d_bit});
        end
        tick();
        rst_n = 1'b1;
        hr = 1'b0;
        ck = 1'b0;
        hits0 = watch_hits;
        watch_en = 1'b1;
        repeat (3) tick();
        for (int y = 6; y < H; y++) drive_line(y, 1'b0);
        frame_close();
        watch_en = 1'b0;
        total++;
        if (watch_hits - hits0 != 0) begin
            bad++;
            $display("FAIL midframe_unarmed_output got=%0d active cycles exp=0", watch_hits - hits0);
        end
        random_image(55);
        run_frame(1'b0);
        total++;
        if (q_e.size() != W * H || q_d.size() != W * H) begin
            bad++;
            $display("FAIL after_reset_count got=%0d/%0d exp=%0d", q_e.size(), q_d.size(), W * H);
        end
        n = min2(min2(q_e.size(), q_d.size()), W * H);
        for (int i = 0; i < n; i++) begin
            total++;
            if (q_e[i] !== golden(i % W, i / W, 1'b0) || q_d[i] !== golden(i % W, i / W, 1'b1)) begin
                bad++;
                $display("FAIL after_reset_pix x=%0d y=%0d got=%0b%0b exp=%0b%0b", i % W, i / W,
                         q_e[i], q_d[i], golden(i % W, i / W, 1'b0), golden(i % W, i / W, 1'b1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_single_dot();
        test_block();
        test_random();
        test_latency_gapped();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vip_bit_morph_3x3.md
Name: vip_bit_morph_3x3

Overview:
Binary 3x3 morphological filter (erosion or dilation) placed directly downstream of the Sobel edge detector.
- Consumes its per_frame_vsync / per_frame_href / per_frame_clken / 1-bit image stream.
- Emits a cleaned 1-bit stream with the same sync protocol, delayed by a fixed 3 clocks.
- Feeds the capture/display path (bit replicated to RGB888 downstream).

Parameters:
IMG_HDISP, 320, active pixels per line; sizes line buffers and column counter.
IMG_VDISP, 240, active lines per frame; sizes row counter.
MODE, 0, 0 = erosion (AND of 9 taps), 1 = dilation (OR of 9 taps).

Ports:
clk  input  1  pixel clock.
rst_n  input  1  reset, asynchronous, active-low.
per_frame_vsync  input  1  frame valid: low = vertical sync, high = frame active.
per_frame_href  input  1  line valid.
per_frame_clken  input  1  pixel enable; a pixel is accepted when href & clken.
per_img_Bit  input  1  input binary pixel.
post_frame_vsync  output  1  per_frame_vsync delayed 3 clk.
post_frame_href  output  1  per_frame_href delayed 3 clk.
post_frame_clken  output  1  per_frame_clken delayed 3 clk, gated by frame_armed (see below).
post_img_Bit  output  1  filtered pixel, aligned with post_frame_clken.

Behaviour:
- Clock/reset: one clock; reset asynchronous, active-low. All outputs, counters, delay lines, line buffers and frame_armed clear to 0.
- Latency: exactly 3 clk from input to output for sync and data, independent of gaps in clken.
- Counters: col (clog2(IMG_HDISP) bits) and row (clog2(IMG_VDISP) bits).
  - Rising edge of per_frame_vsync: col = 0, row = 0, frame_armed = 1.
  - Each accepted pixel: col++, saturating at IMG_HDISP-1.
  - Falling edge of href: col = 0. row++ if at least one pixel was accepted on that line; saturates at IMG_VDISP-1.
- Line buffers: two 1-bit x IMG_HDISP memories, holding rows y-1 and y-2.
  - On each accepted pixel at (col = x, row = y): read both at address x, write current bit into row y-1 buffer at x, shift old row y-1 bit into row y-2 buffer.
  - Read-before-write at the same address.
- Window: columns x-2..x, rows y-2..y. Column shift registers advance only on accepted pixels. Window centre is (x-1, y-1).
- Edge fill: taps with row < 0 (y-2 < 0 or y-1 < 0) or column < 0 are replaced by the neutral value: 1 for erosion, 0 for dilation.
- Border output: post_img_Bit forced to 0 when the originating x == 0 or y == 0. The output image is the filtered image shifted by (+1, +1); downstream accepts this.
- Pipeline:
  - Stage 1: buffer read and tap registration.
  - Stage 2: 3x3 window assembly with edge fill.
  - Stage 3: 9-input AND/OR reduction and border forcing.
- frame_armed: post_frame_clken and post_img_Bit are held 0 until the first vsync rising edge after reset. This prevents misaligned output after a reset mid-frame. post_frame_vsync and post_frame_href always pass through delayed.
- Overlength line (more than IMG_HDISP pixels): extra pixels reuse column IMG_HDISP-1. The output stays well-defined but its data is unspecified.
- Overlength frame: rows beyond IMG_VDISP-1 reuse the last row.
- Simultaneous vsync rise and accepted pixel: the counter reset takes priority and the pixel is treated as (0,0).

Decomposition:
- Package vip_pkg holds:
  - MODE_ERODE = 0 and MODE_DILATE = 1 constants.
  - Width helper function clog2.
- Sub-module vip_bit_matrix_3x3 contains the line buffers, counters and column shifters, and outputs 9 taps plus valid and tap-validity flags.
- The top instantiates it and does edge fill, reduction and sync delay.

Test Plan:
1. All-ones 320x240 frame, MODE=0 -> output 1 everywhere except x==0 or y==0, which are 0. Exactly 76800 output pixels.
2. Single 1 at input (5,5), MODE=1 -> output 1 exactly at x in 5..7, y in 5..7 (9 pixels); all others 0.
3. Single 1 at (5,5), MODE=0 -> all output pixels 0.
4. Solid 3x3 block at x,y in 10..12, MODE=0 -> exactly one output 1, at (12,12).
5. Latency: toggle per_frame_href/per_frame_vsync at a known cycle, with clken gapped every 2nd cycle -> post_* edges appear exactly 3 clk later; post_img_Bit matches the ungapped-run result.
6. rst_n pulsed low at row 100 -> outputs 0 immediately. post_frame_clken stays 0 until the next vsync rising edge. The following frame matches golden output bit-for-bit.
